hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Stall/flush controller at the consumer end of the ID/EX pipeline register.
//  Compares the EX_* fields latched by ID/EX with the instruction now in ID.
//  Detects load-use hazards, taken-branch flushes and data-memory wait.
//  Drives write-enables and flushes back into the PC, IF/ID, ID/EX and EX/MEM registers.
// PARAMETERS
//  REG_AW        3   register-address width (8 GPRs)
//  FLUSH_CYCLES  2   number of cycles IF/ID and ID/EX are flushed after a taken branch (>=1)
//  MEM_TIMEOUT   15  consecutive mem_busy cycles before mem_timeout is set
//  CNT_W         16  width of the statistics counters
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  ID_valid       in   1       ID holds a real instruction
//  ID_rs          in   REG_AW  source reg 1 of the ID instruction
//  ID_rt          in   REG_AW  source reg 2 of the ID instruction
//  ID_uses_rt     in   1       ID instruction reads rt
//  EX_memread     in   1       EX instruction is a load (from ID/EX)
//  EX_rt          in   REG_AW  load destination (from ID/EX)
//  EX_branch_taken in  1       branch resolved taken in EX
//  mem_busy       in   1       data memory not ready this cycle
//  pc_write       out  1       PC update enable
//  ifid_write     out  1       IF/ID load enable
//  ifid_flush     out  1       IF/ID clear to NOP
//  idex_write     out  1       ID/EX load enable
//  idex_flush     out  1       ID/EX load a bubble (all control bits 0)
//  exmem_hold     out  1       EX/MEM hold
//  mem_timeout    out  1       sticky error flag
//  state_o        out  2       current FSM state (debug)
// BEHAVIOUR
//  Reset: state RUN, counters 0, mem_timeout 0.
//    Outputs in reset: pc_write=ifid_write=idex_write=1; ifid_flush, idex_flush, exmem_hold = 0.
//    rst asserted mid-operation aborts any stall or flush immediately.
//  States: RUN=0, LOAD_STALL=1, BR_FLUSH=2, MEM_WAIT=3.
//  Outputs are combinational from state and inputs (same-cycle effect); state is registered.
//  Default outputs = reset values. Priority in RUN / LOAD_STALL: mem_busy > branch > load-use.
//  Freeze: pc_write=ifid_write=idex_write=0, exmem_hold=1, all flushes 0.
//  RUN:
//    mem_busy=1: freeze, go to MEM_WAIT, wait counter=1.
//    else EX_branch_taken=1: ifid_flush=idex_flush=1.
//      If FLUSH_CYCLES>1: go to BR_FLUSH, fcnt=FLUSH_CYCLES-1.
//    else load-use: EX_memread & ID_valid & (EX_rt==ID_rs | ID_uses_rt & EX_rt==ID_rt).
//      Action: pc_write=ifid_write=0, idex_flush=1; go to LOAD_STALL.
//  LOAD_STALL: exactly one cycle, load-use detection masked (EX holds the bubble).
//    mem_busy and branch are handled as in RUN; otherwise return to RUN.
//  BR_FLUSH: ifid_flush=idex_flush=1, decrement fcnt; fcnt==1 -> RUN.
//    mem_busy during BR_FLUSH: freeze; state and fcnt hold.
//  MEM_WAIT: freeze while mem_busy=1 and increment the wait counter.
//    mem_busy=0: outputs return to defaults this cycle; go to RUN.
//    Wait counter reaching MEM_TIMEOUT sets mem_timeout; it stays set until rst.
//    The wait counter saturates at MEM_TIMEOUT.
// CONFIGURATION
//  Macro HAZARD_STATS_EN. When defined, two extra outputs exist, both saturating at all-ones:
//    stall_cnt[CNT_W-1:0] counts cycles with pc_write=0.
//    flush_cnt[CNT_W-1:0] counts cycles with idex_flush=1.
//    Both counters clear on rst.
//  When undefined, neither port nor any counter logic is present.
// STRUCTURE
//  Shared package cpu_pkg holds:
//    REG_AW, and the state encodings RUN / LOAD_STALL / BR_FLUSH / MEM_WAIT.
//  Sub-module sat_counter (width param, inc, clr, value, at_max) is used for:
//    the wait counter, and the stats counters.
// TESTING
//  EX_memread=1, EX_rt=5, ID_rs=5, ID_valid=1
//    -> 1 cycle pc_write=0, idex_flush=1, then RUN with pc_write=1.
//  EX_memread=1, EX_rt=3, ID_rt=3, ID_uses_rt=0
//    -> no stall; the same with ID_uses_rt=1 -> stall.
//  EX_branch_taken pulse with FLUSH_CYCLES=2
//    -> ifid_flush=idex_flush=1 for exactly 2 cycles.
//  Branch and load-use in the same cycle -> flush only, no LOAD_STALL.
//  mem_busy held 20 cycles -> freeze 20 cycles; mem_timeout=1 from wait cycle 15 and stays 1 after mem_busy falls.
//  rst pulse during BR_FLUSH -> state_o=0 and default outputs immediately.
//    With HAZARD_STATS_EN: counters read 0 after the rst pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: register address width and hazard FSM state encodings.
package cpu_pkg;
   localparam int REG_AW = 3;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      BR_FLUSH   = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at MAX; synchronous clear, asynchronous active-high reset.
module sat_counter #(
   parameter int           W   = 4,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         at_max
);
   logic [W-1:0] r_value;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_value <= '0;
      else if (clr)
         r_value <= '0;
      else if (inc && !at_max)
         r_value <= r_value + 1'b1;
   end

   assign value  = r_value;
   assign at_max = (r_value == MAX);
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller at the ID/EX consumer end; define HAZARD_STATS_EN for stall/flush counters.
// state      | meaning
// RUN        | normal issue, all hazards checked
// LOAD_STALL | one-cycle bubble after load-use, load-use check masked
// BR_FLUSH   | flushing IF/ID and ID/EX after a taken branch
// MEM_WAIT   | pipeline frozen while data memory is busy
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 15,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ID_valid,
   input  logic [REG_AW-1:0] ID_rs,
   input  logic [REG_AW-1:0] ID_rt,
   input  logic              ID_uses_rt,
   input  logic              EX_memread,
   input  logic [REG_AW-1:0] EX_rt,
   input  logic              EX_branch_taken,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_write,
   output logic              idex_flush,
   output logic              exmem_hold,
   output logic              mem_timeout,
   output logic [1:0]        state_o
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] TMO_M1 = WW'(MEM_TIMEOUT - 1);

   state_t          r_state, w_state_nxt;
   logic [FW-1:0]   r_fcnt, w_fcnt_nxt;
   logic            r_timeout;
   logic            w_load_use, w_wait_inc, w_wait_clr, w_wait_max, w_tmo_hit;
   logic [WW-1:0]   w_wait_val;

   assign w_load_use = EX_memread & ID_valid &
                       ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RUN;
         r_fcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_fcnt    <= w_fcnt_nxt;
         r_timeout <= r_timeout | w_tmo_hit;
      end
   end

   // rst forces default outputs even though the state register already reads RUN
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_hold  = 1'b0;
      w_wait_inc  = 1'b0;
      w_wait_clr  = 1'b0;
      if (!rst) begin
         case (r_state)
            RUN, LOAD_STALL: begin
               if (mem_busy) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_hold  = 1'b1;
                  w_wait_inc  = 1'b1;
                  w_state_nxt = MEM_WAIT;
               end else if (EX_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     w_state_nxt = BR_FLUSH;
                     w_fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
                  end else begin
                     w_state_nxt = RUN;
                  end
               end else if ((r_state == RUN) && w_load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_flush  = 1'b1;
                  w_state_nxt = LOAD_STALL;
               end else begin
                  w_state_nxt = RUN;
               end
            end
            BR_FLUSH: begin
               if (mem_busy) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_write = 1'b0;
                  exmem_hold = 1'b1;
               end else begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  w_fcnt_nxt = r_fcnt - 1'b1;
                  if (r_fcnt == FW'(1))
                     w_state_nxt = RUN;
               end
            end
            MEM_WAIT: begin
               if (mem_busy) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_write = 1'b0;
                  exmem_hold = 1'b1;
                  w_wait_inc = 1'b1;
               end else begin
                  w_wait_clr  = 1'b1;
                  w_state_nxt = RUN;
               end
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   // Counter holds the number of wait cycles already completed; the flag rises in the cycle that reaches the limit
   sat_counter #(.W(WW), .MAX(WW'(MEM_TIMEOUT))) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_wait_inc & ~w_wait_max),
      .clr   (w_wait_clr),
      .value (w_wait_val),
      .at_max(w_wait_max)
   );

   assign w_tmo_hit   = w_wait_inc & (w_wait_val == TMO_M1);
   assign mem_timeout = r_timeout | w_tmo_hit;
   assign state_o     = r_state;

`ifdef HAZARD_STATS_EN
   logic w_stall_max, w_flush_max;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (~pc_write & ~w_stall_max),
      .clr   (1'b0),
      .value (stall_cnt),
      .at_max(w_stall_max)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (idex_flush & ~w_flush_max),
      .clr   (1'b0),
      .value (flush_cnt),
      .at_max(w_flush_max)
   );
`else
   // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: driver queues expected outputs, negedge monitor compares.
module tb_hazard_ctrl;
   import cpu_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ID_valid = 1'b0;
   logic [REG_AW-1:0] ID_rs = '0;
   logic [REG_AW-1:0] ID_rt = '0;
   logic              ID_uses_rt = 1'b0;
   logic              EX_memread = 1'b0;
   logic [REG_AW-1:0] EX_rt = '0;
   logic              EX_branch_taken = 1'b0;
   logic              mem_busy = 1'b0;
   logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_hold, mem_timeout;
   logic [1:0]        state_o;
`ifdef HAZARD_STATS_EN
   logic [15:0]       stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_uses_rt(ID_uses_rt), .EX_memread(EX_memread), .EX_rt(EX_rt),
      .EX_branch_taken(EX_branch_taken), .mem_busy(mem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush), .exmem_hold(exmem_hold),
      .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_hold}
   localparam logic [5:0] C_DEF = 6'b110100;
   localparam logic [5:0] C_LUS = 6'b000110;
   localparam logic [5:0] C_FLU = 6'b111110;
   localparam logic [5:0] C_FRZ = 6'b000001;

   typedef struct {
      logic [8:0] exp;
      string      nm;
      bit         stats;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   logic [8:0] act;

   assign act = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                 exmem_hold, mem_timeout, state_o};

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (act === e.exp) passes++;
         else $display("FAIL %s: got %b expected %b", e.nm, act, e.exp);
`ifdef HAZARD_STATS_EN
         if (e.stats) begin
            checks++;
            if ({stall_cnt, flush_cnt} === 32'd0) passes++;
            else $display("FAIL stats_clear: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
         end
`endif
      end
   end

   task automatic step(input logic r, v, input logic [REG_AW-1:0] rs, rt,
                       input logic ut, mr, input logic [REG_AW-1:0] ert,
                       input logic bt, mb, input logic [5:0] ctl,
                       input logic tmo, input logic [1:0] st, input string nm,
                       input bit cs = 1'b0);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ID_valid = v; ID_rs = rs; ID_rt = rt; ID_uses_rt = ut;
      EX_memread = mr; EX_rt = ert; EX_branch_taken = bt; mem_busy = mb;
      e.exp = {ctl, tmo, st};
      e.nm = nm;
      e.stats = cs;
      q.push_back(e);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got no finish expected finish by 20000");
      $fatal(1, "watchdog");
   end

   initial begin
      step(1,0,0,0,0,0,0,1,1, C_DEF,0,0, "reset_busy");
      step(1,1,5,0,0,1,5,0,0, C_DEF,0,0, "reset_lu");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,0, "idle");
      step(0,1,5,0,0,1,5,0,0, C_LUS,0,0, "lu_rs");
      step(0,1,5,0,0,1,5,0,0, C_DEF,0,1, "lu_masked");
      step(0,1,5,0,0,0,5,0,0, C_DEF,0,0, "lu_resume");
      step(0,1,0,3,0,1,3,0,0, C_DEF,0,0, "rt_unused");
      step(0,1,0,3,1,1,3,0,0, C_LUS,0,0, "rt_used");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,1, "ls_exit");
      step(0,0,5,0,0,1,5,0,0, C_DEF,0,0, "lu_invalid");
      step(0,0,0,0,0,0,0,1,0, C_FLU,0,0, "br_1");
      step(0,0,0,0,0,0,0,0,0, C_FLU,0,2, "br_2");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,0, "br_done");
      step(0,1,5,0,0,1,5,1,0, C_FLU,0,0, "br_lu_1");
      step(0,1,5,0,0,1,5,0,0, C_FLU,0,2, "br_lu_2");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,0, "br_lu_done");
      step(0,1,5,0,0,1,5,0,0, C_LUS,0,0, "lu_again");
      step(0,1,5,0,0,1,5,1,0, C_FLU,0,1, "ls_branch");
      step(0,0,0,0,0,0,0,0,0, C_FLU,0,2, "ls_br_2");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,0, "ls_br_done");
      step(0,0,0,0,0,0,0,1,0, C_FLU,0,0, "brm_1");
      step(0,0,0,0,0,0,0,0,1, C_FRZ,0,2, "brm_busy");
      step(0,0,0,0,0,0,0,0,0, C_FLU,0,2, "brm_2");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,0, "brm_done");
      step(0,1,5,0,0,1,5,1,1, C_FRZ,0,0, "prio_busy");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,3, "mw_release");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,0, "mw_done");
      for (int i = 1; i <= 20; i++)
         step(0,0,0,0,0,0,0,0,1, C_FRZ, (i >= 15), (i == 1) ? 2'd0 : 2'd3,
              $sformatf("mem_hold_%0d", i));
      step(0,0,0,0,0,0,0,0,0, C_DEF,1,3, "mw_exit_tmo");
      step(0,0,0,0,0,0,0,0,0, C_DEF,1,0, "tmo_sticky");
      step(0,0,0,0,0,0,0,1,0, C_FLU,1,0, "rst_br_1");
      step(1,0,0,0,0,0,0,0,1, C_DEF,0,0, "rst_abort");
      step(0,0,0,0,0,0,0,0,0, C_DEF,0,0, "post_rst", 1'b1);
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0)
         $display("FAIL drain: got %0d pending expected 0", q.size());
      $display("%0d/%0d checks passed", passes, checks + q.size());
      $finish;
   end
endmodule
